spi_sram_responder: RTL and testbench
=====================================

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 SHALL have ports: clk input 1, system clock; rst input 1, asynchronous active-high reset; all logic on rising clk.
REQ-002 SHALL have ports: spi_clk input 1, spi_cs_n input 1, spi_mosi input 1, all asynchronous to clk; spi_miso output 1; spi_miso_oe output 1, high while selected.
REQ-003 SHALL have a memory port: mem_req output 1, mem_we output 1, mem_addr output 16 (byte address), mem_wdata output 8, mem_rdata input 8, mem_ack input 1.
REQ-004 SHALL have status outputs: busy output 1, high while spi_cs_n is low after sync; underrun output 1, sticky read-data-late flag.

Function
REQ-005 SHALL implement SPI mode 0 slave oversampled by clk: 2-flop synchronizers on spi_clk/spi_cs_n/spi_mosi; edges detected between sync stage 2 and a third flop; spi_clk period SHALL be at least 8 clk cycles.
REQ-006 SHALL sample spi_mosi on detected spi_clk rising edges MSB first; update spi_miso on detected falling edges; spi_miso = tx shift MSB while selected, else 0.
REQ-007 FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, MODE_WR, MODE_RD, DISCARD; synced spi_cs_n rising forces IDLE from any state within 1 clk, aborting frame.
REQ-008 IDLE->CMD on synced spi_cs_n falling edge; bit counter loaded to 7.
REQ-009 CMD: after 8 bits, 0x03->ADDR(read), 0x02->ADDR(write), 0x01->MODE_WR, 0x05->MODE_RD, others->DISCARD.
REQ-010 ADDR: shift 16 bits MSB first into address register; then RD_DATA or WR_DATA.
REQ-011 RD_DATA: on 16th address bit issue read at address; also after each 8th data rising edge prefetch address+1; data loaded into tx shift on next falling edge.
REQ-012 Read latency: if mem_ack not seen before the falling edge that loads the byte, load 0x00 and set underrun.
REQ-013 WR_DATA: after each 8 received bits issue write of that byte at current address, then increment address; partial bytes at deselect discarded, not written.
REQ-014 Handshake: mem_req held high with stable mem_we/mem_addr/mem_wdata until the clk cycle mem_ack=1 (ack accepted same cycle); one outstanding request max; mem_rdata captured on mem_ack.
REQ-015 Deselect with request pending: mem_req stays until acked, then drops; read data discarded.
REQ-016 Address increment 16-bit, 0xFFFF wraps to 0x0000 (sequential mode).
REQ-017 DISCARD: ignore mosi, spi_miso=0, until deselect.
REQ-018 underrun cleared only by reset or by a new frame start (IDLE->CMD).

Reset
REQ-019 On rst: state IDLE, counters 0, address 0x0000, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, spi_miso 0, spi_miso_oe 0, busy 0, underrun 0, sync flops 1 (cs/clk idle), mode register 0x40.
REQ-020 rst mid-frame SHALL abort with no further memory request; responder resumes only after next spi_cs_n falling edge.

Configuration
REQ-021 Macro SPI_SRAM_RESPONDER_MODE_REG_EN: defined -> mode register implemented; 0x01 writes bits[7:6], 0x05 returns register byte (repeated) in MODE_RD; 00 byte mode (one data byte, then DISCARD), 10 page mode (address wraps within 32-byte page, bits[4:0]), 01 sequential, 11 treated as sequential.
REQ-022 Undefined -> no mode register; 0x01/0x05 go to DISCARD; always sequential.

Verification
REQ-023 Write 0x02,0x1234,bytes 0xDE 0xAD -> writes (0x1234,0xDE),(0x1235,0xAD), exactly two mem_req.
REQ-024 Read 0x03,0xFFFF, memory returns addr low byte, ack latency 1 -> miso 0xFF 0x00, reads at 0xFFFF then 0x0000, underrun 0.
REQ-025 Read with mem_ack withheld 40 clk -> first byte 0x00, underrun=1; next frame start clears underrun.
REQ-026 Write frame deselected after 0x02,0x0010 and 5 data bits -> no mem_req; following read frame correct.
REQ-027 Command 0x9F -> DISCARD, miso 0, no mem_req; rst asserted mid-write frame -> outputs at reset values next cycle.
REQ-028 MODE_REG_EN: write mode 0x80, write 0x02,0x003F, bytes 0x11 0x22 -> addresses 0x003F then 0x0020; read 0x05 -> 0x80.

Source files
------------

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave that bridges READ/WRITE commands onto a single-outstanding byte memory port.
// Optional mode register (byte/page/sequential) is enabled by SPI_SRAM_RESPONDER_MODE_REG_EN.
module spi_sram_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StRdData, StWrData, StModeWr, StModeRd, StDiscard
  } state_e;

  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic [1:0]  settle_q;
  logic        armed_q;
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  rx_q, tx_q, rd_buf_q;
  logic [15:0] addr_q;
  logic        is_rd_q, load_q, rd_valid_q, rd_stale_q;
  logic        pend_q, pend_we_q;
  logic [15:0] pend_addr_q;
  logic [7:0]  pend_wdata_q;
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
  logic [7:0]  mode_q;
`endif

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic        issue, rd_out, cap, load_evt, kill_rd, in_tx, byte_mode;
  logic [7:0]  rx_next, mode_byte;
  logic [15:0] addr_shift, addr_inc;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign cs_rise    = cs_q[1] & ~cs_q[2];
  // armed_q blocks a frame start from cs_n that was already low across a reset
  assign cs_fall    = ~cs_q[1] & cs_q[2] & armed_q;
  assign mosi_s     = mosi_q[1];
  assign rx_next    = {rx_q[6:0], mosi_s};
  assign addr_shift = {addr_q[14:0], mosi_s};

  assign issue    = pend_q & ~mem_req;
  assign rd_out   = mem_req & ~mem_we & ~mem_ack;
  assign cap      = mem_req & mem_ack & ~mem_we & ~rd_stale_q & (state_q == StRdData);
  assign in_tx    = (state_q == StRdData) | (state_q == StModeRd);
  assign load_evt = sclk_fall & load_q & (state_q == StRdData);
  // Read data that can no longer be used: frame ended or the byte went out as an underrun
  assign kill_rd  = cs_rise | (load_evt & ~rd_valid_q & ~cap);
  assign spi_miso = tx_q[7];

  always_comb begin
    addr_inc  = addr_q + 16'd1;
    byte_mode = 1'b0;
    mode_byte = 8'h00;
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
    mode_byte = mode_q;
    byte_mode = (mode_q[7:6] == 2'b00);
    if (mode_q[7:6] == 2'b10) addr_inc = {addr_q[15:5], addr_q[4:0] + 5'd1};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b111;  cs_q <= 3'b111;  mosi_q <= 2'b11;
      settle_q <= 2'd0;  armed_q <= 1'b0;
      state_q <= StIdle; cnt_q <= 4'd0;   rx_q <= 8'h00;  tx_q <= 8'h00;
      rd_buf_q <= 8'h00; addr_q <= 16'h0000;
      is_rd_q <= 1'b0;   load_q <= 1'b0;  rd_valid_q <= 1'b0; rd_stale_q <= 1'b0;
      pend_q <= 1'b0;    pend_we_q <= 1'b0; pend_addr_q <= 16'h0000; pend_wdata_q <= 8'h00;
      mem_req <= 1'b0;   mem_we <= 1'b0;  mem_addr <= 16'h0000; mem_wdata <= 8'h00;
      spi_miso_oe <= 1'b0; busy <= 1'b0;  underrun <= 1'b0;
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
      mode_q <= 8'h40;
`endif
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      else if (cs_q[1])     armed_q  <= 1'b1;
      busy <= ~cs_q[1];

      if (mem_req & mem_ack) begin
        mem_req    <= 1'b0;
        rd_stale_q <= 1'b0;
      end else if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= pend_we_q;
        mem_addr  <= pend_addr_q;
        mem_wdata <= pend_wdata_q;
        pend_q    <= 1'b0;
      end
      if (cap) begin
        rd_valid_q <= 1'b1;
        rd_buf_q   <= mem_rdata;
      end
      if (kill_rd) begin
        if ((issue & ~pend_we_q) | rd_out) rd_stale_q <= 1'b1;
        if (pend_q & ~pend_we_q & ~issue)  pend_q     <= 1'b0;
      end

      if (cs_rise) begin
        state_q <= StIdle; spi_miso_oe <= 1'b0; tx_q <= 8'h00; load_q <= 1'b0; cnt_q <= 4'd0;
      end else if (cs_fall) begin
        state_q <= StCmd;  spi_miso_oe <= 1'b1; tx_q <= 8'h00; load_q <= 1'b0; cnt_q <= 4'd7;
        underrun <= 1'b0;  rd_valid_q <= 1'b0;
      end else begin
        if (sclk_rise) begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          case (state_q)
            StCmd: begin
              rx_q <= rx_next;
              if (cnt_q == 4'd0) begin
                case (rx_next)
                  8'h03: begin state_q <= StAddr; is_rd_q <= 1'b1; cnt_q <= 4'd15; end
                  8'h02: begin state_q <= StAddr; is_rd_q <= 1'b0; cnt_q <= 4'd15; end
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
                  8'h01: begin state_q <= StModeWr; cnt_q <= 4'd7; end
                  8'h05: begin state_q <= StModeRd; cnt_q <= 4'd7; load_q <= 1'b1; end
`endif
                  default: state_q <= StDiscard;
                endcase
              end
            end
            StAddr: begin
              addr_q <= addr_shift;
              if (cnt_q == 4'd0) begin
                cnt_q <= 4'd7;
                if (is_rd_q) begin
                  state_q <= StRdData; load_q <= 1'b1;
                  pend_q <= 1'b1; pend_we_q <= 1'b0; pend_addr_q <= addr_shift;
                end else begin
                  state_q <= StWrData;
                end
              end
            end
            StRdData: begin
              if (cnt_q == 4'd0) begin
                cnt_q <= 4'd7;
                if (byte_mode) begin
                  state_q <= StDiscard; tx_q <= 8'h00;
                end else begin
                  addr_q <= addr_inc; load_q <= 1'b1;
                  pend_q <= 1'b1; pend_we_q <= 1'b0; pend_addr_q <= addr_inc;
                end
              end
            end
            StWrData: begin
              rx_q <= rx_next;
              if (cnt_q == 4'd0) begin
                cnt_q <= 4'd7;
                addr_q <= addr_inc;
                pend_q <= 1'b1; pend_we_q <= 1'b1; pend_addr_q <= addr_q; pend_wdata_q <= rx_next;
                if (byte_mode) state_q <= StDiscard;
              end
            end
            StModeWr: begin
              rx_q <= rx_next;
              if (cnt_q == 4'd0) begin
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
                mode_q[7:6] <= rx_next[7:6];
`endif
                state_q <= StDiscard;
              end
            end
            StModeRd: begin
              if (cnt_q == 4'd0) begin
                cnt_q <= 4'd7; load_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (sclk_fall & in_tx) begin
          if (load_q) begin
            load_q <= 1'b0;
            if (state_q == StModeRd) begin
              tx_q <= mode_byte;
            end else begin
              rd_valid_q <= 1'b0;
              if (rd_valid_q)  tx_q <= rd_buf_q;
              else if (cap)    tx_q <= mem_rdata;
              else begin
                tx_q <= 8'h00; underrun <= 1'b1;
              end
            end
          end else begin
            tx_q <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  logic unused_load_evt;
  assign unused_load_evt = load_evt;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: directed vector table, random write/read-back
// frames against a byte-array reference, and hand-written corner sequences.
module tb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_req, mem_we, busy, underrun;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  spi_sram_responder dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
  localparam logic [15:0] ModeRdExp = 16'h4040;
`else
  localparam logic [15:0] ModeRdExp = 16'h0000;
`endif

  typedef struct packed {logic we; logic [15:0] a; logic [7:0] d;} req_t;
  req_t log_q[$];

  // Memory model: unwritten locations read back as their address low byte
  bit [7:0] mem [65536];
  bit       mem_wr [65536];
  int       ack_lat = 0;
  int       wait_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0; mem_rdata <= 8'h00; wait_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= ack_lat) begin
          mem_ack   <= 1'b1;
          wait_cnt  <= 0;
          mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : mem_addr[7:0];
          if (mem_we) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
          end
          log_q.push_back({mem_we, mem_addr, mem_wdata});
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Reference contents as the specification's address rules predict them
  bit [7:0] ref_mem [65536];
  bit       ref_wr [65536];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : a[7:0];
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  logic [7:0] txd [8];
  logic [7:0] rxd [8];

  task automatic half_bit();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] t, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = t[i];
      half_bit();
      spi_clk = 1'b1;
      r[i] = spi_miso;
      half_bit();
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end();
    half_bit();
    spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr, input int nb);
    logic [7:0] junk;
    log_q.delete();
    spi_cs_n = 1'b0;
    half_bit();
    spi_bits(cmd, 8, junk);
    if (cmd == 8'h02 || cmd == 8'h03) begin
      spi_bits(addr[15:8], 8, junk);
      spi_bits(addr[7:0], 8, junk);
    end
    for (int i = 0; i < nb; i++) spi_bits(txd[i], 8, rxd[i]);
    frame_end();
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rx;
    int          exp_nreq;  // -1: trailing prefetch makes the count uninteresting
    int          nlog;
    logic        exp_we;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] ra, ea;
  logic [31:0] rnd;
  int          n;
  logic [7:0]  junk8;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h02, 16'h1234, 16'hDEAD, 16'h0000, 2, 2, 1'b1, 16'h1234, 16'h1235, 8'hDE, 8'hAD};
    vecs[1] = '{8'h03, 16'h1234, 16'h0000, 16'hDEAD, -1, 2, 1'b0, 16'h1234, 16'h1235, 8'h00, 8'h00};
    vecs[2] = '{8'h03, 16'hFFFF, 16'h0000, 16'hFF00, -1, 2, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 8'h00};
    vecs[3] = '{8'h9F, 16'h0000, 16'h5A5A, 16'h0000, 0, 0, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00};
    vecs[4] = '{8'h05, 16'h0000, 16'h0000, ModeRdExp, 0, 0, 1'b0, 16'h0, 16'h0, 8'h00, 8'h00};
    vecs[5] = '{8'h01, 16'h0000, 16'h4000, 16'h0000, 0, 0, 1'b0, 16'h0, 16'h0, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst miso", 32'(spi_miso), 32'd0);
    chk("rst miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      txd[0] = vecs[v].wd[15:8];
      txd[1] = vecs[v].wd[7:0];
      do_frame(vecs[v].cmd, vecs[v].addr, 2);
      chk($sformatf("vec%0d rx", v), 32'({rxd[0], rxd[1]}), 32'(vecs[v].exp_rx));
      if (vecs[v].exp_nreq >= 0)
        chk($sformatf("vec%0d nreq", v), 32'(log_q.size()), 32'(vecs[v].exp_nreq));
      for (int k = 0; k < vecs[v].nlog; k++) begin
        chk($sformatf("vec%0d req%0d we", v, k), 32'(log_q[k].we), 32'(vecs[v].exp_we));
        chk($sformatf("vec%0d req%0d addr", v, k), 32'(log_q[k].a),
            32'(k == 0 ? vecs[v].a0 : vecs[v].a1));
        if (vecs[v].exp_we)
          chk($sformatf("vec%0d req%0d data", v, k), 32'(log_q[k].d),
              32'(k == 0 ? vecs[v].d0 : vecs[v].d1));
      end
      chk($sformatf("vec%0d underrun", v), 32'(underrun), 32'd0);
      if (vecs[v].exp_we) begin
        ref_mem[vecs[v].a0] = vecs[v].d0; ref_wr[vecs[v].a0] = 1'b1;
        ref_mem[vecs[v].a1] = vecs[v].d1; ref_wr[vecs[v].a1] = 1'b1;
      end
    end

    // Random sequential write bursts, each read back through the responder
    for (int it = 0; it < 8; it++) begin
      rnd = $urandom;
      ra = (it == 0) ? 16'hFFFE : rnd[15:0];
      n = $urandom_range(3, 1);
      ack_lat = $urandom_range(2, 0);
      for (int k = 0; k < n; k++) begin
        rnd = $urandom;
        txd[k] = rnd[7:0];
      end
      do_frame(8'h02, ra, n);
      chk($sformatf("rnd%0d nwrites", it), 32'(log_q.size()), 32'(n));
      for (int k = 0; k < n; k++) begin
        ea = ra + 16'(k);
        chk($sformatf("rnd%0d w%0d", it, k), 32'(log_q[k]), 32'({1'b1, ea, txd[k]}));
        ref_mem[ea] = txd[k];
        ref_wr[ea] = 1'b1;
      end
      for (int k = 0; k < n; k++) txd[k] = 8'h00;
      do_frame(8'h03, ra, n);
      for (int k = 0; k < n; k++)
        chk($sformatf("rnd%0d r%0d", it, k), 32'(rxd[k]), 32'(ref_rd(ra + 16'(k))));
      chk($sformatf("rnd%0d underrun", it), 32'(underrun), 32'd0);
    end
    ack_lat = 0;

    // Acknowledge withheld past the load point
    ack_lat = 40;
    txd[0] = 8'h00; txd[1] = 8'h00;
    do_frame(8'h03, 16'h0100, 2);
    chk("late first byte", 32'(rxd[0]), 32'd0);
    chk("late underrun set", 32'(underrun), 32'd1);
    repeat (120) @(negedge clk);
    ack_lat = 0;
    spi_cs_n = 1'b0;
    half_bit();
    chk("underrun cleared by frame start", 32'(underrun), 32'd0);
    spi_bits(8'h9F, 8, junk8);
    frame_end();

    // Write frame cut short inside the first data byte
    log_q.delete();
    spi_cs_n = 1'b0;
    half_bit();
    spi_bits(8'h02, 8, junk8);
    spi_bits(8'h00, 8, junk8);
    spi_bits(8'h10, 8, junk8);
    spi_bits(8'hA5, 5, junk8);
    frame_end();
    chk("partial byte nreq", 32'(log_q.size()), 32'd0);
    txd[0] = 8'h00;
    do_frame(8'h03, 16'h0010, 1);
    chk("read after partial", 32'(rxd[0]), 32'(ref_rd(16'h0010)));

    // Reset in the middle of a write frame, cs_n held low across it
    log_q.delete();
    spi_cs_n = 1'b0;
    half_bit();
    spi_bits(8'h02, 8, junk8);
    spi_bits(8'h02, 4, junk8);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst miso", 32'(spi_miso), 32'd0);
    chk("midrst miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    spi_bits(8'h00, 4, junk8);
    spi_bits(8'h77, 8, junk8);
    frame_end();
    chk("after rst nreq", 32'(log_q.size()), 32'd0);
    txd[0] = 8'h00; txd[1] = 8'h00;
    do_frame(8'h03, 16'h1234, 2);
    chk("resume read", 32'({rxd[0], rxd[1]}), 32'({ref_rd(16'h1234), ref_rd(16'h1235)}));

`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
    txd[0] = 8'h80;
    do_frame(8'h01, 16'h0000, 1);
    txd[0] = 8'h11; txd[1] = 8'h22;
    do_frame(8'h02, 16'h003F, 2);
    chk("page nwrites", 32'(log_q.size()), 32'd2);
    chk("page w0", 32'(log_q[0]), 32'({1'b1, 16'h003F, 8'h11}));
    chk("page w1", 32'(log_q[1]), 32'({1'b1, 16'h0020, 8'h22}));
    txd[0] = 8'h00;
    do_frame(8'h05, 16'h0000, 1);
    chk("mode read", 32'(rxd[0]), 32'h80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
